// File: rtl/axi_vga_pkg.sv
// axi_vga_pkg: shared RGB565 pixel format and word packing helpers
package axi_vga_pkg;
  localparam int PixelWidth = 16;
  localparam int RedWidth = 5;
  localparam int GreenWidth = 6;
  localparam int BlueWidth = 5;
  localparam int RedLsb = 11;
  localparam int GreenLsb = 5;
  localparam int BlueLsb = 0;
  typedef struct packed {
    logic [RedWidth-1:0] red;
    logic [GreenWidth-1:0] green;
    logic [BlueWidth-1:0] blue;
  } pixel_t;
  function automatic int ppw(input int data_width, input int pixel_width);
    return data_width / pixel_width;
  endfunction
endpackage

// File: rtl/axi_vga_word_fifo.sv
// axi_vga_word_fifo: synchronous word FIFO with flush and fill count
module axi_vga_word_fifo #(
  parameter int Width = 64,
  parameter int Depth = 16,
  localparam int AddrW = $clog2(Depth),
  localparam int FillW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [FillW-1:0] fill
);
  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  assign full = fill == FillW'(Depth);
  assign empty = fill == '0;
  // pointers and occupancy; flush discards everything stored
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (push) wptr <= wptr + AddrW'(1);
      if (pop) rptr <= rptr + AddrW'(1);
      fill <= fill + FillW'(push) - FillW'(pop);
    end
  // storage needs no reset: a reset pointer pair marks it empty
  always_ff @(posedge clk_i)
    if (push && !flush) mem[wptr] <= wdata;
endmodule

// File: rtl/axi_vga_pixel_unpacker.sv
// axi_vga_pixel_unpacker: buffers framebuffer words and streams them out as RGB pixels
module axi_vga_pixel_unpacker
  import axi_vga_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int PixelWidth = axi_vga_pkg::PixelWidth,
  parameter int RedWidth = axi_vga_pkg::RedWidth,
  parameter int GreenWidth = axi_vga_pkg::GreenWidth,
  parameter int BlueWidth = axi_vga_pkg::BlueWidth,
  parameter int FifoDepth = 16,
  parameter int CntWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic                           flush_i,
  input  logic [DataWidth-1:0]           data_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  output logic [RedWidth-1:0]            red_o,
  output logic [GreenWidth-1:0]          green_o,
  output logic [BlueWidth-1:0]           blue_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] fill_o,
  output logic                           underrun_o,
  output logic [CntWidth-1:0]            underrun_cnt_o,
  input  logic                           underrun_clr_i
);
  localparam int Ppw = ppw(DataWidth, PixelWidth);
  localparam int IdxW = Ppw > 1 ? $clog2(Ppw) : 1;
  logic flush_c, push, pop, hs, last, full, empty, word_valid;
  logic [DataWidth-1:0] word, head;
  logic [IdxW-1:0] idx;
  logic [PixelWidth-1:0] pix;
  assign flush_c = flush_i | ~enable_i;
  assign data_ready_o = ~flush_c & ~full;
  assign push = data_valid_i & data_ready_o;
  assign hs = word_valid & ready_i;
  assign last = idx == IdxW'(Ppw - 1);
  assign pop = ~flush_c & ~empty & (~word_valid | (hs & last));
  assign valid_o = word_valid;
  assign pix = word[idx*PixelWidth +: PixelWidth];
  assign red_o = word_valid ? pix[PixelWidth-1 -: RedWidth] : '0;
  assign green_o = word_valid ? pix[BlueWidth +: GreenWidth] : '0;
  assign blue_o = word_valid ? pix[BlueWidth-1:0] : '0;
  assign underrun_o = enable_i & ~flush_i & ready_i & ~word_valid;
  axi_vga_word_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush(flush_c),
    .push(push),
    .pop(pop),
    .wdata(data_i),
    .rdata(head),
    .full(full),
    .empty(empty),
    .fill(fill_o)
  );
  // unpack register: refill from the FIFO on the last pixel so output has no bubble
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      word <= '0;
      idx <= '0;
      word_valid <= 1'b0;
    end else if (flush_c) begin
      idx <= '0;
      word_valid <= 1'b0;
    end else if (pop) begin
      word <= head;
      idx <= '0;
      word_valid <= 1'b1;
    end else if (hs) begin
      idx <= last ? '0 : idx + IdxW'(1);
      word_valid <= ~last;
    end
  // saturating underrun counter; clear beats increment
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) underrun_cnt_o <= '0;
    else if (underrun_clr_i) underrun_cnt_o <= '0;
    else if (underrun_o && !(&underrun_cnt_o)) underrun_cnt_o <= underrun_cnt_o + CntWidth'(1);
endmodule

// File: tb/tb_axi_vga_pixel_unpacker.sv
// tb_axi_vga_pixel_unpacker: directed and randomized checks against a pixel-queue model
module tb_axi_vga_pixel_unpacker;
  import axi_vga_pkg::*;
  logic clk, rst_n, enable, flush, data_valid, data_ready, valid, ready, underrun, uclr;
  logic [63:0] data;
  logic [4:0] red, blue, fill;
  logic [5:0] green;
  logic [15:0] ucnt;
  logic [63:0] src_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] prev_pix, exp_cnt;
  logic [63:0] w;
  bit send_en, gap_chk, prev_stall;
  int total, bad, pix_cnt, base;

  axi_vga_pixel_unpacker dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready),
    .red_o(red), .green_o(green), .blue_o(blue), .valid_o(valid), .ready_i(ready),
    .fill_o(fill), .underrun_o(underrun), .underrun_cnt_o(ucnt), .underrun_clr_i(uclr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic fl, und_e;
    pixel_t p;
    data_valid = send_en && src_q.size() != 0;
    data = data_valid ? src_q[0] : '0;
    #1;
    fl = flush || !enable;
    und_e = enable && !flush && ready && !valid;
    chk("underrun_cnt", ucnt, exp_cnt);
    chk("underrun_pulse", underrun, und_e);
    if (prev_stall) chk("stall_stable", {valid, red, green, blue}, {1'b1, prev_pix});
    if (!valid) chk("rgb_zero_idle", {red, green, blue}, 16'h0);
    if (gap_chk && exp_q.size() != 0) chk("no_gap", valid, 1'b1);
    if (fl) chk("no_accept_in_flush", data_ready, 1'b0);
    if (valid && ready) begin
      chk("pixel_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("pixel", {red, green, blue}, {p.red, p.green, p.blue});
      end
      pix_cnt++;
    end
    if (fl) exp_q.delete();
    if (data_valid && data_ready) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(data[k*16 +: 16]);
      void'(src_q.pop_front());
    end
    exp_cnt = uclr ? 16'h0 : (und_e && exp_cnt != 16'hFFFF) ? exp_cnt + 16'd1 : exp_cnt;
    prev_stall = valid && !ready && !fl;
    prev_pix = {red, green, blue};
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (src_q.size() != 0 || exp_q.size() != 0); i++) tick();
    chk(tag, src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0; pix_cnt = 0; exp_cnt = 0;
    send_en = 0; gap_chk = 0; prev_stall = 0; prev_pix = 0;
    rst_n = 0; enable = 0; flush = 0; data_valid = 0; data = '0; ready = 0; uclr = 0;
    #1;
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_rgb", {red, green, blue}, 16'h0);
    chk("rst_fill", fill, 5'd0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_cnt", ucnt, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    enable = 1;
    // single word, first-pixel latency and order
    ready = 1;
    tick();
    send_en = 1;
    src_q.push_back(64'h0000_001F_07E0_F800);
    tick();
    chk("latency_n1_valid", valid, 1'b0);
    tick();
    chk("latency_n2_valid", valid, 1'b1);
    chk("first_pixel", {red, green, blue}, {5'h1F, 6'h00, 5'h00});
    repeat (4) tick();
    chk("single_end_valid", valid, 1'b0);
    chk("single_end_underrun", underrun, 1'b1);
    // fill the FIFO with the sink stalled, then stream back to back
    ready = 0;
    for (int i = 0; i < 20; i++) src_q.push_back({$urandom, $urandom});
    w = src_q[0];
    repeat (25) tick();
    chk("full_fill", fill, 5'd16);
    chk("full_data_ready", data_ready, 1'b0);
    chk("full_valid", valid, 1'b1);
    chk("full_head_pixel", {red, green, blue}, w[15:0]);
    send_en = 0;
    src_q.delete();
    ready = 1;
    gap_chk = 1;
    base = pix_cnt;
    drain("full_drain");
    gap_chk = 0;
    chk("full_pixel_count", pix_cnt - base, 68);
    // random sink backpressure over 64 words
    send_en = 1;
    for (int i = 0; i < 64; i++) src_q.push_back({$urandom, $urandom});
    for (int i = 0; i < 4000 && (src_q.size() != 0 || exp_q.size() != 0); i++) begin
      ready = $urandom_range(0, 1);
      tick();
    end
    chk("random_drain", src_q.size() + exp_q.size(), 0);
    // flush at pixel index 2 with five words queued
    ready = 0;
    for (int i = 0; i < 6; i++) src_q.push_back({$urandom, $urandom});
    repeat (10) tick();
    ready = 1;
    repeat (2) tick();
    ready = 0;
    chk("pre_flush_fill", fill, 5'd5);
    flush = 1;
    tick();
    flush = 0;
    chk("post_flush_fill", fill, 5'd0);
    chk("post_flush_valid", valid, 1'b0);
    w = {$urandom, $urandom};
    src_q.push_back(w);
    repeat (3) tick();
    chk("post_flush_pixel0", {valid, red, green, blue}, {1'b1, w[15:0]});
    ready = 1;
    drain("flush_drain");
    // disable blocks acceptance and underrun reporting
    enable = 0;
    src_q.push_back({$urandom, $urandom});
    tick();
    chk("disabled_data_ready", data_ready, 1'b0);
    chk("disabled_underrun", underrun, 1'b0);
    tick();
    enable = 1;
    drain("reenable_drain");
    // asynchronous reset in the middle of traffic
    ready = 0;
    for (int i = 0; i < 3; i++) src_q.push_back({$urandom, $urandom});
    repeat (5) tick();
    rst_n = 0;
    #1;
    chk("midrst_fill", fill, 5'd0);
    chk("midrst_valid", {valid, red, green, blue}, 17'h0);
    chk("midrst_cnt", ucnt, 16'h0);
    exp_q.delete();
    src_q.delete();
    exp_cnt = 0;
    prev_stall = 0;
    @(posedge clk);
    #2 rst_n = 1;
    repeat (3) tick();
    chk("midrst_stays_empty", {valid, fill}, 6'h0);
    // underrun counter saturation and clear priority
    send_en = 0;
    ready = 1;
    uclr = 1;
    tick();
    uclr = 0;
    repeat (70000) tick();
    chk("cnt_saturated", ucnt, 16'hFFFF);
    uclr = 1;
    tick();
    uclr = 0;
    chk("cnt_cleared", ucnt, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
